// File: rtl/boss_pkg.sv
`default_nettype none
// ============================================================================
// boss_pkg : shared types and screen constants for the boss fire path
// Rev 1.0  : initial release
// ============================================================================
package boss_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COOLDOWN = 3'd1,
    AIM      = 3'd2,
    FIRE     = 3'd3,
    GAP      = 3'd4
  } fire_state_t;

  localparam int SCREEN_WIDTH  = 200;
  localparam int SCREEN_HEIGHT = 300;
  localparam int BULLET_WIDTH  = 5;
  localparam int BULLET_HEIGHT = 5;
  localparam int Y_MAX         = SCREEN_HEIGHT - BULLET_HEIGHT;

endpackage
`default_nettype wire

// File: rtl/boss_fire_ctrl_if.sv
`default_nettype none
// ============================================================================
// boss_fire_ctrl_if : boss position in, launch command out
// Rev 1.0  : initial release
// ============================================================================
interface boss_fire_ctrl_if;

  logic       enable;
  logic       frame_tick;
  logic [9:0] boss_x;
  logic [8:0] boss_y;
  logic [8:0] char_y;
  logic       fire;
  logic [9:0] start_x;
  logic [8:0] start_y;
  logic [2:0] state_o;
  logic [3:0] shot_idx;

  modport master (
    output enable, frame_tick, boss_x, boss_y, char_y,
    input  fire, start_x, start_y, state_o, shot_idx
  );

  modport slave (
    input  enable, frame_tick, boss_x, boss_y, char_y,
    output fire, start_x, start_y, state_o, shot_idx
  );

endinterface
`default_nettype wire

// File: rtl/boss_frame_timer.sv
`default_nettype none
// ============================================================================
// boss_frame_timer : 8-bit frame tick counter, done on the limit-th tick
// Rev 1.0  : initial release
// ============================================================================
module boss_frame_timer (
  input  wire       clk,
  input  wire       reset,
  input  wire       clear,
  input  wire       tick,
  input  wire [7:0] limit,
  output logic      done
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign done = tick && (r_count == (limit - 8'd1));

endmodule
`default_nettype wire

// File: rtl/boss_fire_ctrl.sv
`default_nettype none
// ============================================================================
// boss_fire_ctrl : burst/gap/cooldown fire scheduler feeding boss_bullet
// Optional macro BOSS_FIRE_AIM_TRACK_EN : launch Y leans toward the player
// Rev 1.0  : initial release
// ============================================================================
module boss_fire_ctrl #(
  parameter int COOLDOWN_FRAMES = 60,
  parameter int GAP_FRAMES      = 8,
  parameter int BURST_LEN       = 3,
  parameter int Y_OFFSET        = 12,
  parameter int Y_MAX           = boss_pkg::Y_MAX
) (
  input  wire             clk,
  input  wire             reset,
  boss_fire_ctrl_if.slave bus
);

  import boss_pkg::*;

  localparam logic [7:0] C_COOL      = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] C_GAP       = 8'(GAP_FRAMES);
  localparam logic [3:0] C_LAST_SHOT = 4'(BURST_LEN - 1);
  localparam logic [9:0] C_Y_OFF     = 10'(Y_OFFSET);
  localparam logic [9:0] C_Y_MAX     = 10'(Y_MAX);

  fire_state_t r_state;
  fire_state_t w_next;
  logic [3:0]  r_shot;
  logic [3:0]  w_shot_next;
  logic        w_load;
  logic        r_fire;
  logic [9:0]  r_start_x;
  logic [8:0]  r_start_y;
  logic [8:0]  w_aim_y;
  logic        w_counting;
  logic        w_count_tick;
  logic        w_count_clear;
  logic        w_timer_done;
  logic [7:0]  w_limit;

  // Ticks only count while waiting; AIM/FIRE/IDLE hold the counter at zero.
  assign w_counting    = (r_state == COOLDOWN) || (r_state == GAP);
  assign w_count_tick  = bus.frame_tick && bus.enable && w_counting;
  assign w_count_clear = !w_counting || !bus.enable || w_timer_done;
  assign w_limit       = (r_state == GAP) ? C_GAP : C_COOL;

  boss_frame_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_count_clear),
    .tick  (w_count_tick),
    .limit (w_limit),
    .done  (w_timer_done)
  );

`ifdef BOSS_FIRE_AIM_TRACK_EN
  logic [9:0] w_band_hi_raw;
  logic [9:0] w_band_hi;

  assign w_band_hi_raw = {1'b0, bus.boss_y} + (C_Y_OFF << 1);
  assign w_band_hi     = (w_band_hi_raw > C_Y_MAX) ? C_Y_MAX : w_band_hi_raw;

  always_comb begin
    w_aim_y = bus.char_y;
    if ({1'b0, bus.char_y} > w_band_hi) begin
      w_aim_y = w_band_hi[8:0];
    end else if (bus.char_y < bus.boss_y) begin
      w_aim_y = bus.boss_y;
    end
  end
`else
  logic [9:0] w_off_sum;
  logic       w_unused_char_y;

  // 10-bit sum so a low boss near the bottom saturates instead of wrapping.
  assign w_off_sum       = {1'b0, bus.boss_y} + C_Y_OFF;
  assign w_aim_y         = (w_off_sum > C_Y_MAX) ? C_Y_MAX[8:0] : w_off_sum[8:0];
  assign w_unused_char_y = ^bus.char_y;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_shot_next = r_shot;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = COOLDOWN;
      end
      COOLDOWN: begin
        if (w_timer_done) begin
          w_next      = AIM;
          w_shot_next = '0;
        end
      end
      AIM: begin
        w_load = 1'b1;
        w_next = FIRE;
      end
      FIRE: begin
        if (r_shot == C_LAST_SHOT) begin
          w_shot_next = '0;
          w_next      = COOLDOWN;
        end else begin
          w_shot_next = r_shot + 4'd1;
          w_next      = GAP;
        end
      end
      GAP: begin
        if (w_timer_done) begin
          w_next = AIM;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Dropping enable abandons any burst in progress.
    if (!bus.enable) begin
      w_next      = IDLE;
      w_shot_next = '0;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shot    <= '0;
      r_fire    <= 1'b0;
      r_start_x <= '0;
      r_start_y <= '0;
    end else begin
      r_shot <= w_shot_next;
      r_fire <= (r_state == FIRE) && bus.enable;
      if (w_load) begin
        r_start_x <= bus.boss_x;
        r_start_y <= w_aim_y;
      end
    end
  end

  assign bus.fire     = r_fire;
  assign bus.start_x  = r_start_x;
  assign bus.start_y  = r_start_y;
  assign bus.state_o  = r_state;
  assign bus.shot_idx = r_shot;

endmodule
`default_nettype wire

// File: tb/tb_boss_fire_ctrl.sv
`default_nettype none
// ============================================================================
// tb_boss_fire_ctrl : directed + random checks against a tick-countdown model
// Rev 1.0  : initial release
// ============================================================================
module tb_boss_fire_ctrl;

  localparam int COOL  = 60;
  localparam int GAPF  = 8;
  localparam int BURST = 3;
  localparam int YOFF  = 12;
  localparam int YMAX  = 295;
`ifdef BOSS_FIRE_AIM_TRACK_EN
  localparam int BY_RAND_MAX = 280;
`else
  localparam int BY_RAND_MAX = 511;
`endif

  localparam int P_IDLE = 0;
  localparam int P_COOL = 1;
  localparam int P_AIM  = 2;
  localparam int P_FIRE = 3;
  localparam int P_GAP  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  boss_fire_ctrl_if bus ();

  boss_fire_ctrl #(
    .COOLDOWN_FRAMES (COOL),
    .GAP_FRAMES      (GAPF),
    .BURST_LEN       (BURST),
    .Y_OFFSET        (YOFF),
    .Y_MAX           (YMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase, ticks still needed before the next shot, next shot number.
  int m_ph, m_left, m_shot, m_sx, m_sy;
  bit m_fire;
  bit prev_fire;
  int prev_sx, prev_sy;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_y(input int by, input int cy);
`ifdef BOSS_FIRE_AIM_TRACK_EN
    int hi;
    hi = (by + 2 * YOFF < YMAX) ? by + 2 * YOFF : YMAX;
    if (cy > hi) return hi;
    if (cy < by) return by;
    return cy;
`else
    return (by + YOFF > YMAX) ? YMAX : by + YOFF;
`endif
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_left = 0; m_shot = 0; m_sx = 0; m_sy = 0; m_fire = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit tk, input int bx, input int by, input int cy);
    m_fire = (m_ph == P_FIRE) && en;
    if (!en) begin
      m_ph = P_IDLE; m_shot = 0; m_left = 0;
    end else begin
      case (m_ph)
        P_IDLE: begin m_ph = P_COOL; m_left = COOL; end
        P_COOL, P_GAP: begin
          if (tk) begin
            m_left--;
            if (m_left == 0) begin
              if (m_ph == P_COOL) m_shot = 0;
              m_ph = P_AIM;
            end
          end
        end
        P_AIM: begin m_sx = bx; m_sy = exp_y(by, cy); m_ph = P_FIRE; end
        default: begin
          if (m_shot == BURST - 1) begin
            m_shot = 0; m_ph = P_COOL; m_left = COOL;
          end else begin
            m_shot++; m_ph = P_GAP; m_left = GAPF;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit en, input bit tk, input int bx, input int by, input int cy);
    prev_fire = bus.fire;
    prev_sx   = int'(bus.start_x);
    prev_sy   = int'(bus.start_y);
    bus.enable     = en;
    bus.frame_tick = tk;
    bus.boss_x     = 10'(bx);
    bus.boss_y     = 9'(by);
    bus.char_y     = 9'(cy);
    @(posedge clk);
    model_step(en, tk, bx, by, cy);
    @(negedge clk);
    check("fire",       int'(bus.fire),     int'(m_fire));
    check("start_x",    int'(bus.start_x),  m_sx);
    check("start_y",    int'(bus.start_y),  m_sy);
    check("state",      int'(bus.state_o),  m_ph);
    check("shot_idx",   int'(bus.shot_idx), m_shot);
    check("fire_width", int'(bus.fire && prev_fire), 0);
  endtask

  // Enable held high, tick every `period` cycles; returns cycles until fire is seen.
  task automatic run_until_fire(input int by, input int cy, input int period, output int steps);
    steps = 0;
    for (int s = 1; s <= 2000; s++) begin
      step(1'b1, (s % period) == 0, 150, by, cy);
      if (bus.fire) begin
        steps = s;
        return;
      end
    end
    check("fire_timeout", int'(bus.fire), 1);
  endtask

  initial begin
    int n;
    int fires;
    bus.enable = 1'b0; bus.frame_tick = 1'b0;
    bus.boss_x = '0; bus.boss_y = '0; bus.char_y = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_fire",  int'(bus.fire),     0);
    check("rst_state", int'(bus.state_o),  P_IDLE);
    check("rst_shot",  int'(bus.shot_idx), 0);
    check("rst_sx",    int'(bus.start_x),  0);
    check("rst_sy",    int'(bus.start_y),  0);
    reset = 1'b0;

    // First burst, tick every 10 cycles: 60 ticks then AIM, FIRE, fire.
    run_until_fire(100, 40, 10, n);
    check("first_fire_cycles", n, 602);
    check("sx_before_fire", prev_sx, 150);
`ifdef BOSS_FIRE_AIM_TRACK_EN
    check("sy_before_fire", prev_sy, 100);
`else
    check("sy_before_fire", prev_sy, 112);
`endif
    check("shot_after_1", int'(bus.shot_idx), 1);
    run_until_fire(100, 40, 10, n);
    check("gap1_cycles", n, 82);
    check("shot_after_2", int'(bus.shot_idx), 2);
    run_until_fire(100, 40, 10, n);
    check("gap2_cycles", n, 82);
    check("shot_after_3", int'(bus.shot_idx), 0);
    check("state_after_3", int'(bus.state_o), P_COOL);

    // Saturation near the bottom, then the top edge; ticks every cycle.
    run_until_fire(290, 40, 1, n);
    check("cool_cycles", n, 62);
`ifdef BOSS_FIRE_AIM_TRACK_EN
    check("sy_sat", int'(bus.start_y), 290);
`else
    check("sy_sat", int'(bus.start_y), 295);
`endif
    run_until_fire(0, 40, 1, n);
    check("gap_tick_cycles", n, 10);
`ifdef BOSS_FIRE_AIM_TRACK_EN
    check("sy_zero", int'(bus.start_y), 24);
`else
    check("sy_zero", int'(bus.start_y), 12);
`endif

    // Async reset while fire is high.
    reset = 1'b1;
    #1;
    check("mid_rst_fire",  int'(bus.fire),     0);
    check("mid_rst_state", int'(bus.state_o),  P_IDLE);
    check("mid_rst_shot",  int'(bus.shot_idx), 0);
    check("mid_rst_sx",    int'(bus.start_x),  0);
    check("mid_rst_sy",    int'(bus.start_y),  0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Enable dropped right after the second fire; re-enable restarts cooldown.
    run_until_fire(100, 40, 1, n);
    check("idle_start_cycles", n, 63);
    run_until_fire(100, 40, 1, n);
    check("second_fire_cycles", n, 10);
    step(1'b0, 1'b1, 150, 100, 40);
    check("drop_state", int'(bus.state_o), P_IDLE);
    fires = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 150, 100, 40);
      if (bus.fire) fires++;
    end
    check("fires_while_disabled", fires, 0);
    run_until_fire(100, 40, 1, n);
    check("reenable_cycles", n, 63);

    // Launch Y for three player heights.
    run_until_fire(100, 40, 1, n);
    check("aim40_cycles", n, 10);
`ifdef BOSS_FIRE_AIM_TRACK_EN
    check("aim40_sy", int'(bus.start_y), 100);
`else
    check("aim40_sy", int'(bus.start_y), 112);
`endif
    run_until_fire(100, 115, 1, n);
    check("aim115_cycles", n, 10);
`ifdef BOSS_FIRE_AIM_TRACK_EN
    check("aim115_sy", int'(bus.start_y), 115);
`else
    check("aim115_sy", int'(bus.start_y), 112);
`endif
    run_until_fire(100, 200, 1, n);
    check("aim200_cycles", n, 62);
`ifdef BOSS_FIRE_AIM_TRACK_EN
    check("aim200_sy", int'(bus.start_y), 124);
`else
    check("aim200_sy", int'(bus.start_y), 112);
`endif

    // Random enable/tick/position traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 97, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 1023)), int'($urandom_range(0, BY_RAND_MAX)),
           int'($urandom_range(0, 511)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boss_fire_ctrl.md
Name: boss_fire_ctrl

Overview:
Upstream fire scheduler for the final boss's bullet block (boss_bullet).
- Counts frame ticks.
- Fires bursts of shots separated by gaps, then rests for a cooldown.
- For each shot, latches the launch coordinates and issues a one-cycle fire pulse.
- Sits between the boss movement logic and boss_bullet, driving that block's fire/start_x/start_y inputs.

Parameters:
COOLDOWN_FRAMES, 60, frame ticks spent in COOLDOWN before a burst starts (1..255)
GAP_FRAMES, 8, frame ticks between shots inside a burst (1..255)
BURST_LEN, 3, shots per burst (1..15)
Y_OFFSET, 12, vertical offset added to boss_y for the launch point
Y_MAX, 295, largest legal start_y (screen height 300 minus bullet height 5)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  boss alive and game running; low forces IDLE
frame_tick  input  1  one-cycle pulse per video frame
boss_x  input  10  current boss X
boss_y  input  9  current boss Y
char_y  input  9  player Y (used only with AIM_TRACK_EN)
fire  output  1  one-cycle pulse to boss_bullet
start_x  output  10  registered launch X, held between shots
start_y  output  9  registered launch Y, held between shots
state_o  output  3  current FSM state, for debug/HUD
shot_idx  output  4  index of the next shot within the current burst

Behaviour:
- Reset (async, active-high) sets:
  - state = IDLE
  - fire = 0, start_x = 0, start_y = 0, shot_idx = 0
  - frame counter = 0
- States:
  - IDLE
    - enable=1 -> COOLDOWN, frame counter cleared.
  - COOLDOWN
    - Counter increments on frame_tick.
    - On the tick where counter == COOLDOWN_FRAMES-1: -> AIM, counter cleared, shot_idx = 0.
  - AIM (exactly one cycle)
    - start_x <= boss_x.
    - start_y <= min(boss_y + Y_OFFSET, Y_MAX). Add in 10 bits, saturate, then truncate to 9 bits.
    - -> FIRE.
  - FIRE (exactly one cycle)
    - fire = 1 in this cycle only.
    - If shot_idx == BURST_LEN-1: shot_idx <= 0, -> COOLDOWN.
    - Else: shot_idx <= shot_idx+1, -> GAP.
    - Counter cleared in both cases.
  - GAP
    - Counts frame_tick.
    - On the tick where counter == GAP_FRAMES-1: -> AIM.
- Latency:
  - start_x/start_y are valid one cycle before fire rises.
  - Both stay stable while fire is high and until the next AIM.
- fire is a registered output, decoded from the registered FIRE state. It is never high for two consecutive cycles.
- enable low in any state:
  - Next cycle the FSM is in IDLE, the counter is cleared, shot_idx = 0 and fire = 0.
  - start_x/start_y hold their last values.
  - enable low takes priority over frame_tick in the same cycle.
- frame_tick that arrives during AIM or FIRE is ignored; the counter restarts from 0 after FIRE.
- Re-enabling always starts from a full COOLDOWN; a partial burst is never resumed.
- Reset asserted mid-burst: immediate return to reset values; no fire glitch.
- boss_bullet ignores fire while its bullet is active. Pulses dropped this way are intentional, and this block does not retry them.

Optional Feature:
BOSS_FIRE_AIM_TRACK_EN
- Defined: in AIM, start_y <= clamp(char_y, boss_y, min(boss_y + 2*Y_OFFSET, Y_MAX)). Shots lean toward the player but stay within the boss's body band.
- Undefined: start_y uses the fixed offset rule; char_y is unused, with a lint waiver.

Decomposition:
- Shared package boss_pkg holds:
  - fire_state_t enum: IDLE=0, COOLDOWN=1, AIM=2, FIRE=3, GAP=4
  - SCREEN_WIDTH=200, SCREEN_HEIGHT=300
  - BULLET_WIDTH=5, BULLET_HEIGHT=5
  - Y_MAX derived as SCREEN_HEIGHT-BULLET_HEIGHT
- One natural sub-module: boss_frame_timer.
  - 8-bit frame_tick counter with clear, and a done output asserted when count == limit-1 on a tick.
  - Instantiated once; the limit is muxed between COOLDOWN_FRAMES and GAP_FRAMES by state.

Test Plan:
- Reset release, enable=1, boss_x=150, boss_y=100, a tick every 10 cycles -> first fire after exactly 60 ticks; start_x=150, start_y=112 one cycle before fire.
- Full burst with defaults -> exactly 3 fire pulses, each 1 cycle wide, spaced 8 ticks apart; shot_idx sequence 0,1,2,0; then COOLDOWN.
- boss_y=290 -> start_y saturates to 295 (no 9-bit wrap); boss_y=0 -> start_y=12.
- enable dropped one cycle after the second fire -> IDLE next cycle, no third fire; re-enable -> 60-tick cooldown before the next fire.
- frame_tick coincident with AIM/FIRE and enable=0 coincident with a tick -> tick ignored and enable wins respectively; no fire emitted.
- BOSS_FIRE_AIM_TRACK_EN defined, boss_y=100, char_y=40/115/200 -> start_y=100/115/124.
